// File: rtl/core_dmem_responder_pkg.sv
// core_dmem_responder shared definitions: FSM state encodings,
// byte-lane width and a strobe lane-count helper.
package core_dmem_responder_pkg;

   localparam int LANE_W = 8;

   localparam logic [1:0] DMEM_IDLE = 2'd0;
   localparam logic [1:0] DMEM_WAIT = 2'd1;
   localparam logic [1:0] DMEM_RESP = 2'd2;

   function automatic logic [2:0] lane_cnt(input logic [3:0] s);
      return 3'(s[0]) + 3'(s[1]) + 3'(s[2]) + 3'(s[3]);
   endfunction

endpackage

// File: rtl/core_dmem_load_align.sv
// core_dmem_load_align: combinational load extraction from a memory word.
// Ports: w (word), addr_lo (ADDR[1:0]), strb, is_bs, is_hws -> rdata.
module core_dmem_load_align
   import core_dmem_responder_pkg::*;
(
   input  logic [31:0] w,
   input  logic [1:0]  addr_lo,
   input  logic [3:0]  strb,
   input  logic        is_bs,
   input  logic        is_hws,
   output logic [31:0] rdata
);

   logic [LANE_W-1:0]   byte_v;
   logic [2*LANE_W-1:0] half_v;

   // Lane choice comes from the address; the strobe only sets the width.
   always_comb begin
      byte_v = LANE_W'(w >> {addr_lo, 3'b000});
      half_v = (2*LANE_W)'(w >> {addr_lo[1], 4'b0000});
      rdata  = '0;
      case (lane_cnt(strb))
         3'd4: rdata = w;
         3'd1: rdata = {{24{is_bs & byte_v[7]}}, byte_v};
         3'd2: rdata = {{16{is_hws & half_v[15]}}, half_v};
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/core_dmem_responder.sv
// core_dmem_responder: data-memory slave answering ISLOAD_SS/ISSTORE_SS.
// Ports: CLK, NRST (sync, active low), ISLOAD_SS, ISSTORE_SS, ADDR, WDATA,
//   STRB, ISLOADBS, ISLOADHWS in; RDATA, BUSY, DONE out; ERR out only
//   when DMEM_MISALIGN_CHECK_EN is defined (alignment/range fault flag).
module core_dmem_responder
   import core_dmem_responder_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] MEM_BASE    = 32'h0000_0000
)
(
   input  logic        CLK,
   input  logic        NRST,
   input  logic        ISLOAD_SS,
   input  logic        ISSTORE_SS,
   input  logic [31:0] ADDR,
   input  logic [31:0] WDATA,
   input  logic [3:0]  STRB,
   input  logic        ISLOADBS,
   input  logic        ISLOADHWS,
   output logic [31:0] RDATA,
   output logic        BUSY,
   output logic        DONE
`ifdef DMEM_MISALIGN_CHECK_EN
   ,
   output logic        ERR
`endif
);

   localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   logic [1:0]       state;
   logic [3:0]       cnt;
   logic [31:0]      req_addr;
   logic [31:0]      req_wdata;
   logic [3:0]       req_strb;
   logic             req_bs;
   logic             req_hws;
   logic             req_store;
   logic [31:0]      mem [DEPTH_WORDS];

   logic             accept;
   logic             finish;
   logic [29:0]      woff;
   logic             in_range;
   logic [IDX_W-1:0] idx;
   logic [31:0]      word;
   logic [31:0]      ld_val;
   logic             fault;
   logic             commit;

   assign accept = (ISLOAD_SS | ISSTORE_SS) &&
                   (state == DMEM_IDLE || state == DMEM_RESP);
   assign finish = (state == DMEM_WAIT) && (cnt == 4'd0);

   assign woff     = 30'((req_addr - MEM_BASE) >> 2);
   assign in_range = (req_addr >= MEM_BASE) &&
                     ({2'b00, woff} < 32'(DEPTH_WORDS));
   assign idx      = woff[IDX_W-1:0];
   assign word     = in_range ? mem[idx] : '0;

`ifdef DMEM_MISALIGN_CHECK_EN
   always_comb begin
      fault = 1'b0;
      case (lane_cnt(req_strb))
         3'd4: fault = (req_addr[1:0] != 2'b00);
         3'd1: fault = (req_strb != (4'b0001 << req_addr[1:0]));
         3'd2: fault = req_addr[0] ||
                       (req_strb != (req_addr[1] ? 4'b1100 : 4'b0011));
         default: fault = 1'b0;
      endcase
   end
`else
   assign fault = 1'b0;
`endif

   assign commit = finish && req_store && in_range && !fault;

   core_dmem_load_align u_align (
      .w       (word),
      .addr_lo (req_addr[1:0]),
      .strb    (req_strb),
      .is_bs   (req_bs),
      .is_hws  (req_hws),
      .rdata   (ld_val)
   );

   // Array has no reset; a reset edge also blocks a pending commit.
   always_ff @(posedge CLK) begin
      if (NRST && commit) begin
         for (int i = 0; i < 4; i++) begin
            if (req_strb[i])
               mem[idx][LANE_W*i +: LANE_W] <= req_wdata[LANE_W*i +: LANE_W];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!NRST) begin
         state     <= DMEM_IDLE;
         cnt       <= '0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         RDATA     <= '0;
         req_addr  <= '0;
         req_wdata <= '0;
         req_strb  <= '0;
         req_bs    <= 1'b0;
         req_hws   <= 1'b0;
         req_store <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
         ERR       <= 1'b0;
`endif
      end else begin
         DONE <= 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
         ERR  <= 1'b0;
`endif
         if (accept) begin
            // Store wins when both start pulses arrive together.
            req_addr  <= ADDR;
            req_wdata <= WDATA;
            req_strb  <= STRB;
            req_bs    <= ISLOADBS;
            req_hws   <= ISLOADHWS;
            req_store <= ISSTORE_SS;
            cnt       <= 4'(LATENCY - 1);
            BUSY      <= 1'b1;
            state     <= DMEM_WAIT;
         end else if (finish) begin
            state <= DMEM_RESP;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
`ifdef DMEM_MISALIGN_CHECK_EN
            ERR   <= fault || !in_range;
`endif
            // Faulting loads return zero; stores never touch RDATA.
            if (!req_store)
               RDATA <= (in_range && !fault) ? ld_val : '0;
         end else if (state == DMEM_WAIT) begin
            cnt <= cnt - 4'd1;
         end else if (state == DMEM_RESP) begin
            state <= DMEM_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_core_dmem_responder.sv
// Scoreboard bench for core_dmem_responder with a lane-level memory model.
// Stimulus expects pushed at issue; monitor pops on every DONE.
module tb_core_dmem_responder;

   localparam int          DEPTH = 1024;
   localparam int          LAT   = 2;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic        CLK = 1'b0;
   logic        NRST = 1'b0;
   logic        ISLOAD_SS = 1'b0;
   logic        ISSTORE_SS = 1'b0;
   logic [31:0] ADDR = '0;
   logic [31:0] WDATA = '0;
   logic [3:0]  STRB = '0;
   logic        ISLOADBS = 1'b0;
   logic        ISLOADHWS = 1'b0;
   logic [31:0] RDATA;
   logic        BUSY;
   logic        DONE;
`ifdef DMEM_MISALIGN_CHECK_EN
   logic        ERR;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] model_mem [int];
   logic [31:0] model_rdata = '0;

   always #5 CLK = ~CLK;

   core_dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (LAT),
      .MEM_BASE    (BASE)
   ) dut (
      .CLK        (CLK),
      .NRST       (NRST),
      .ISLOAD_SS  (ISLOAD_SS),
      .ISSTORE_SS (ISSTORE_SS),
      .ADDR       (ADDR),
      .WDATA      (WDATA),
      .STRB       (STRB),
      .ISLOADBS   (ISLOADBS),
      .ISLOADHWS  (ISLOADHWS),
      .RDATA      (RDATA),
      .BUSY       (BUSY),
      .DONE       (DONE)
`ifdef DMEM_MISALIGN_CHECK_EN
      ,
      .ERR        (ERR)
`endif
   );

   task automatic check(input string name, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic logic model_oor(input logic [31:0] a);
      if (a < BASE) return 1'b1;
      return ((a - BASE) / 4) >= DEPTH;
   endfunction

   function automatic logic model_fault(input logic [31:0] a,
                                        input logic [3:0] s);
`ifdef DMEM_MISALIGN_CHECK_EN
      int n;
      int lo;
      n  = $countones(s);
      lo = int'(a[1:0]);
      if (n == 4) return lo != 0;
      if (n == 1) return !s[lo];
      if (n == 2) return a[0] || !(s[lo] && s[lo+1]);
      return 1'b0;
`else
      return 1'b0 & a[0] & s[0];
`endif
   endfunction

   function automatic logic [31:0] model_word(input logic [31:0] a);
      int k;
      k = int'((a - BASE) / 4);
      return model_mem.exists(k) ? model_mem[k] : 32'h0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a,
      input logic [3:0] s, input logic bs, input logic hws);
      logic [31:0] w;
      logic [31:0] v;
      int n;
      w = model_word(a);
      n = $countones(s);
      if (n == 4) return w;
      if (n == 1) begin
         v = (w / (32'd1 << (8 * a[1:0]))) % 256;
         if (bs && v >= 128) v = v - 256;
         return v;
      end
      if (n == 2) begin
         v = (w / (32'd1 << (16 * a[1]))) % 65536;
         if (hws && v >= 32768) v = v - 65536;
         return v;
      end
      return 32'h0;
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s);
      logic [31:0] w;
      w = model_word(a);
      for (int i = 0; i < 4; i++)
         if (s[i]) w[8*i +: 8] = d[8*i +: 8];
      model_mem[int'((a - BASE) / 4)] = w;
   endtask

   // Drives one start pulse (accepted on the next edge) and records the expect.
   task automatic start_op(input logic st, input logic both,
      input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
      input logic bs, input logic hws);
      exp_t e;
      ISSTORE_SS = st;
      ISLOAD_SS  = !st || both;
      ADDR = a; WDATA = d; STRB = s;
      ISLOADBS = bs; ISLOADHWS = hws;
      @(posedge CLK); #1;
      ISSTORE_SS = 1'b0;
      ISLOAD_SS  = 1'b0;
      e.err = model_fault(a, s) || model_oor(a);
      if (st) begin
         if (!e.err) model_store(a, d, s);
      end else begin
         model_rdata = e.err ? 32'h0 : model_load(a, s, bs, hws);
      end
      e.rdata = model_rdata;
      sb.push_back(e);
      check("busy_rise", {31'd0, BUSY}, 32'd1);
   endtask

   task automatic wait_done(input int exp_n);
      int n;
      int busy_n;
      n = 0;
      busy_n = 0;
      while (!DONE && n < 40) begin
         if (BUSY) busy_n++;
         @(posedge CLK); #1;
         n++;
      end
      check("done_lat", n, exp_n);
      check("busy_cycles", busy_n, exp_n);
      check("busy_fall", {31'd0, BUSY}, 32'd0);
   endtask

   task automatic finish_idle();
      @(posedge CLK); #1;
      check("done_width", {31'd0, DONE}, 32'd0);
   endtask

   task automatic op(input logic st, input logic [31:0] a,
      input logic [31:0] d, input logic [3:0] s,
      input logic bs, input logic hws);
      start_op(st, 1'b0, a, d, s, bs, hws);
      wait_done(LAT);
      finish_idle();
   endtask

   always @(negedge CLK) begin
      if (NRST && DONE) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected_done got=DONE exp=none");
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_rdata", RDATA, e.rdata);
`ifdef DMEM_MISALIGN_CHECK_EN
            check("sb_err", {31'd0, ERR}, {31'd0, e.err});
`endif
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   logic [3:0] strb_tab [8];

   initial begin
      strb_tab = '{4'b1111, 4'b0001, 4'b0010, 4'b0100,
                   4'b1000, 4'b0011, 4'b1100, 4'b0000};

      repeat (3) @(posedge CLK);
      #1;
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      check("rst_done", {31'd0, DONE}, 32'd0);
      check("rst_rdata", RDATA, 32'd0);
      NRST = 1'b1;
      @(posedge CLK); #1;

      op(1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 0);
      op(0, 32'h10, 32'h0, 4'b1111, 0, 0);
      check("lw_10", RDATA, 32'hDEADBEEF);

      op(0, 32'h13, 32'h0, 4'b1000, 1, 0);
      check("lb_s", RDATA, 32'hFFFFFFDE);
      op(0, 32'h13, 32'h0, 4'b1000, 0, 0);
      check("lb_u", RDATA, 32'h000000DE);

      op(1, 32'h20, 32'h11223344, 4'b1111, 0, 0);
      op(1, 32'h22, 32'hAAAA5555, 4'b1100, 0, 0);
      check("sh_keeps_rdata", RDATA, 32'h000000DE);
      op(0, 32'h20, 32'h0, 4'b1111, 0, 0);
      check("lw_20", RDATA, 32'hAAAA3344);
      op(0, 32'h22, 32'h0, 4'b1100, 0, 1);
      check("lh_s", RDATA, 32'hFFFFAAAA);

      // Back-to-back: next start during the DONE cycle.
      start_op(1, 0, 32'h24, 32'hCAFEF00D, 4'b1111, 0, 0);
      wait_done(LAT);
      start_op(0, 0, 32'h24, 32'h0, 4'b1111, 0, 0);
      check("b2b_done_low", {31'd0, DONE}, 32'd0);
      wait_done(LAT);
      finish_idle();
      check("b2b_lw", RDATA, 32'hCAFEF00D);

      // Start during WAIT must be ignored.
      op(1, 32'h2C, 32'h5A5A5A5A, 4'b1111, 0, 0);
      start_op(1, 0, 32'h28, 32'h01010101, 4'b1111, 0, 0);
      ISSTORE_SS = 1'b1; ADDR = 32'h2C; WDATA = 32'hBADBAD00;
      @(posedge CLK); #1;
      ISSTORE_SS = 1'b0;
      wait_done(LAT - 1);
      finish_idle();
      repeat (3) @(posedge CLK);
      #1;
      op(0, 32'h2C, 32'h0, 4'b1111, 0, 0);
      check("wait_start_ignored", RDATA, 32'h5A5A5A5A);

      // Both starts together: store wins.
      start_op(1, 1, 32'h34, 32'h0F0E0D0C, 4'b1111, 0, 0);
      wait_done(LAT);
      finish_idle();
      check("both_keeps_rdata", RDATA, 32'h5A5A5A5A);
      op(0, 32'h34, 32'h0, 4'b1111, 0, 0);
      check("both_store_won", RDATA, 32'h0F0E0D0C);

      // Reset in the middle of a store.
      op(1, 32'h30, 32'h77665544, 4'b1111, 0, 0);
      ISSTORE_SS = 1'b1; ADDR = 32'h30; WDATA = 32'h12345678;
      STRB = 4'b1111;
      @(posedge CLK); #1;
      ISSTORE_SS = 1'b0;
      NRST = 1'b0;
      @(posedge CLK); #1;
      check("midrst_busy", {31'd0, BUSY}, 32'd0);
      check("midrst_done", {31'd0, DONE}, 32'd0);
      check("midrst_rdata", RDATA, 32'd0);
      NRST = 1'b1;
      model_rdata = '0;
      @(posedge CLK); #1;
      op(0, 32'h30, 32'h0, 4'b1111, 0, 0);
      check("midrst_old", RDATA, 32'h77665544);

      op(0, BASE + 4 * DEPTH, 32'h0, 4'b1111, 0, 0);
      check("oor_lw", RDATA, 32'h0);
      op(0, 32'h30, 32'h0, 4'b1111, 0, 0);
      op(1, BASE + 4 * DEPTH, 32'hFFFFFFFF, 4'b1111, 0, 0);
      check("oor_sw_rdata", RDATA, 32'h77665544);
`ifdef DMEM_MISALIGN_CHECK_EN
      op(0, 32'h11, 32'h0, 4'b1111, 0, 0);
      check("misalign_lw", RDATA, 32'h0);
`endif

      for (int i = 0; i < 16; i++)
         op(1, 32'(4 * i), $urandom, 4'b1111, 0, 0);

      for (int i = 0; i < 120; i++) begin
         logic        st;
         logic [31:0] a;
         st = 1'($urandom_range(0, 1));
         a  = 32'($urandom_range(0, 63));
         if ($urandom_range(0, 9) == 0)
            a = BASE + 4 * DEPTH + 32'($urandom_range(0, 255));
         op(st, a, $urandom, strb_tab[$urandom_range(0, 7)],
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(posedge CLK);
      #1;
      check("sb_leftover", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
